tlb_ctrl: RTL and testbench
===========================

Name: tlb_ctrl

Overview:
Sequences the MIPS TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR against the 16-entry dual-search TLB. Owns the TLB-related CP0 registers: Index, EntryHi, EntryLo0, EntryLo1, Random and Wired. Sits between the WB stage and CP0 on one side and the TLB's search port 1, read port and write port on the other. Issues a pipeline flush request after any op that can change address mappings.

Parameters:
TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM) is the index width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  TLB op request from WB
op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_ready  out  1  controller idle, can accept an op
op_done  out  1  one-cycle pulse when the op completes
flush_req  out  1  one-cycle pulse with op_done for TLBR/TLBWI/TLBWR
mtc0_we  in  1  CP0 write strobe
mtc0_addr  in  5  CP0 register number: Index 0, EntryLo0 2, EntryLo1 3, Wired 6, EntryHi 10
mtc0_wdata  in  32  CP0 write data
cp0_index, cp0_entrylo0, cp0_entrylo1, cp0_entryhi, cp0_random, cp0_wired  out  32 each  register values for MFC0 and the MMU
s_vpn2  out  19  search key to TLB search port 1 (EntryHi[31:13])
s_asid  out  8  EntryHi[7:0]
s_found  in  1  TLB search hit
s_index  in  IW  TLB search hit index
r_index  out  IW  TLB read index
r_entry  in  78  read entry bus {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}
tlb_we  out  1  TLB write enable
w_index  out  IW  TLB write index
w_entry  out  78  write entry bus, same layout as r_entry

Behaviour:
- Clock and reset: one clock, clk; reset resetn is asynchronous and active-low.
- Reset values: FSM in IDLE; Index, EntryHi, EntryLo0, EntryLo1 and Wired = 0; Random = TLBNUM-1; op_done, flush_req and tlb_we = 0. TLB contents are not reset.
- FSM states: IDLE, PROBE, READ, WRITE. op_ready = (state==IDLE).
- Acceptance: an op is accepted on a clock edge where op_valid && op_ready.
  - TLBP goes to PROBE.
  - TLBR goes to READ.
  - TLBWI and TLBWR go to WRITE, latching wr_idx = Index[IW-1:0] or Random[IW-1:0] respectively.
- Every op state lasts exactly one cycle. op_done is asserted during that cycle, then the FSM returns to IDLE. Latency is accept edge + 1 cycle, and back-to-back ops give a throughput of one op per 2 cycles.
- PROBE: s_vpn2/s_asid are driven from EntryHi in all states (the search is combinational).
  - At the end of PROBE: Index[31] <= !s_found; Index[IW-1:0] <= s_found ? s_index : unchanged.
- READ: r_index = Index[IW-1:0]. At the end of READ:
  - EntryHi <= {vpn2, 5'b0, asid}.
  - EntryLo0 <= {6'b0, pfn0, c0, d0, v0, g}.
  - EntryLo1 <= {6'b0, pfn1, c1, d1, v1, g}.
- WRITE: tlb_we = 1 for exactly that cycle, with w_index = wr_idx.
  - w_entry is built from EntryHi[31:13], EntryHi[7:0], g = EntryLo0[0] & EntryLo1[0], and the pfn/c/d/v fields of EntryLo0/1 ([25:6], [5:3], [2], [1]).
- flush_req = op_done && op_code_latched != TLBP.
- Random:
  - Decrements every cycle.
  - When Random == Wired, the next value is TLBNUM-1.
  - An mtc0 write to Wired sets Random = TLBNUM-1 on the same edge.
  - Random is read-only via mtc0.
- mtc0 writable masks:
  - Index: [IW-1:0] only; P bit is read-only.
  - EntryHi: [31:13] and [7:0].
  - EntryLo0/1: [25:0].
  - Wired: [IW-1:0].
  - All other bits read 0.
- Write collision: if an FSM update and an mtc0 hit the same register on the same edge, the FSM update wins. Non-conflicting registers take the mtc0 write.
- op_valid while !op_ready is ignored; the requester holds op_valid until accepted.
- Reset asserted mid-op: the FSM returns to IDLE immediately. No tlb_we or op_done is produced after reset asserts.
- Multiple TLB hits: s_index is taken as supplied and not checked.

Decomposition:
- Package tlb_pkg:
  - Op-code constants TLBOP_P/R/WI/WR.
  - CP0 register numbers.
  - TLB_ENTRY_W = 78 and the field offsets of the entry bus.
  - FSM state enum.
  - Pack/unpack functions for the entry bus.
- Sub-module tlb_random_cnt: the Random counter with wrap at Wired and reload on a Wired write.

Test Plan:
- Reset release -> cp0_random = 15, decrements each cycle, 15 -> 0 -> 15; op_ready = 1.
- mtc0 Wired = 4 -> Random reloads 15 and counts 15..4, then 15.
- mtc0 EntryHi = 0x0040_2005, EntryLo0 = 0x0000_1047, EntryLo1 = 0x0000_1087, Index = 3, then TLBWI -> single-cycle tlb_we, w_index = 3, vpn2 = 0x00201, asid = 0x05, g = 1, pfn0 = 0x41, c0 = 0, d0 = 1, v0 = 1; op_done = flush_req = 1.
- TLBP with a matching EntryHi after the previous write -> Index = 0x0000_0003. TLBP with EntryHi asid = 0x06 and entry g = 0 -> Index[31] = 1 and Index[3:0] keeps its previous value.
- TLBR with Index = 3 -> EntryHi = 0x0040_2005 and EntryLo0/1 match the written values; TLBWR -> w_index equals the Random value at acceptance.
- mtc0 to Index on the PROBE-end edge -> the probe result wins. Reset asserted during WRITE -> tlb_we drops immediately, FSM is IDLE.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance controller: op codes, CP0 register
// numbers, the 78-bit TLB entry bus layout and the controller FSM states.
package tlb_pkg;

   localparam int TLBNUM = 16;
   localparam int IW     = $clog2(TLBNUM);

   localparam logic [1:0] TLBOP_P  = 2'b00;
   localparam logic [1:0] TLBOP_R  = 2'b01;
   localparam logic [1:0] TLBOP_WI = 2'b10;
   localparam logic [1:0] TLBOP_WR = 2'b11;

   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_WIRED    = 5'd6;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

   localparam logic [31:0] MASK_ENTRYHI = 32'hFFFF_E0FF;
   localparam logic [31:0] MASK_ENTRYLO = 32'h03FF_FFFF;

   localparam int TLB_ENTRY_W = 78;
   localparam int OFS_V1   = 0;
   localparam int OFS_D1   = 1;
   localparam int OFS_C1   = 2;
   localparam int OFS_PFN1 = 5;
   localparam int OFS_V0   = 25;
   localparam int OFS_D0   = 26;
   localparam int OFS_C0   = 27;
   localparam int OFS_PFN0 = 30;
   localparam int OFS_G    = 50;
   localparam int OFS_ASID = 51;
   localparam int OFS_VPN2 = 59;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PROBE = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } tlb_state_e;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   function automatic logic [TLB_ENTRY_W-1:0] tlb_pack(input tlb_entry_t e);
      logic [TLB_ENTRY_W-1:0] b;
      b = '0;
      b[OFS_VPN2 +: 19] = e.vpn2;
      b[OFS_ASID +: 8]  = e.asid;
      b[OFS_G]          = e.g;
      b[OFS_PFN0 +: 20] = e.pfn0;
      b[OFS_C0 +: 3]    = e.c0;
      b[OFS_D0]         = e.d0;
      b[OFS_V0]         = e.v0;
      b[OFS_PFN1 +: 20] = e.pfn1;
      b[OFS_C1 +: 3]    = e.c1;
      b[OFS_D1]         = e.d1;
      b[OFS_V1]         = e.v1;
      return b;
   endfunction

   function automatic tlb_entry_t tlb_unpack(input logic [TLB_ENTRY_W-1:0] b);
      tlb_entry_t e;
      e.vpn2 = b[OFS_VPN2 +: 19];
      e.asid = b[OFS_ASID +: 8];
      e.g    = b[OFS_G];
      e.pfn0 = b[OFS_PFN0 +: 20];
      e.c0   = b[OFS_C0 +: 3];
      e.d0   = b[OFS_D0];
      e.v0   = b[OFS_V0];
      e.pfn1 = b[OFS_PFN1 +: 20];
      e.c1   = b[OFS_C1 +: 3];
      e.d1   = b[OFS_D1];
      e.v1   = b[OFS_V1];
      return e;
   endfunction

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random: free-running down counter that wraps to TLBNUM-1 once it reaches
// Wired, and reloads TLBNUM-1 whenever Wired is written.
module tlb_random_cnt
   import tlb_pkg::*;
(
   input  logic          clk,
   input  logic          resetn,
   input  logic          wired_we_i,
   input  logic [IW-1:0] wired_i,
   output logic [IW-1:0] random_o
);

   localparam logic [IW-1:0] RAND_MAX = IW'(TLBNUM - 1);

   logic [IW-1:0] random_q, random_d;

   always_comb begin
      random_d = random_q - 1'b1;
      if (wired_we_i || (random_q == wired_i)) begin
         random_d = RAND_MAX;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         random_q <= RAND_MAX;
      end else begin
         random_q <= random_d;
      end
   end

   assign random_o = random_q;

endmodule

// File: rtl/tlb_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the TLB and owns the TLB-related CP0
// registers. Each op occupies one cycle after acceptance, then returns to idle.
module tlb_ctrl
   import tlb_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   op_valid,
   input  logic [1:0]             op_code,
   output logic                   op_ready,
   output logic                   op_done,
   output logic                   flush_req,
   input  logic                   mtc0_we,
   input  logic [4:0]             mtc0_addr,
   input  logic [31:0]            mtc0_wdata,
   output logic [31:0]            cp0_index,
   output logic [31:0]            cp0_entrylo0,
   output logic [31:0]            cp0_entrylo1,
   output logic [31:0]            cp0_entryhi,
   output logic [31:0]            cp0_random,
   output logic [31:0]            cp0_wired,
   output logic [18:0]            s_vpn2,
   output logic [7:0]             s_asid,
   input  logic                   s_found,
   input  logic [IW-1:0]          s_index,
   output logic [IW-1:0]          r_index,
   input  logic [TLB_ENTRY_W-1:0] r_entry,
   output logic                   tlb_we,
   output logic [IW-1:0]          w_index,
   output logic [TLB_ENTRY_W-1:0] w_entry
);

   tlb_state_e    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [31:0]   index_q, index_d;
   logic [31:0]   entryhi_q, entryhi_d;
   logic [31:0]   entrylo0_q, entrylo0_d;
   logic [31:0]   entrylo1_q, entrylo1_d;
   logic [IW-1:0] wired_q, wired_d;
   logic [IW-1:0] random;
   logic          wired_we;
   tlb_entry_t    rd_e, wr_e;

   assign wired_we = mtc0_we && (mtc0_addr == CP0_WIRED);
   assign rd_e     = tlb_unpack(r_entry);

   tlb_random_cnt u_random (
      .clk        (clk),
      .resetn     (resetn),
      .wired_we_i (wired_we),
      .wired_i    (wired_q),
      .random_o   (random)
   );

   // mtc0 writes are applied first so that an FSM update on the same edge overrides them.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wr_idx_d   = wr_idx_q;
      index_d    = index_q;
      entryhi_d  = entryhi_q;
      entrylo0_d = entrylo0_q;
      entrylo1_d = entrylo1_q;
      wired_d    = wired_q;

      if (mtc0_we) begin
         case (mtc0_addr)
            CP0_INDEX:    index_d[IW-1:0] = mtc0_wdata[IW-1:0];
            CP0_ENTRYHI:  entryhi_d       = mtc0_wdata & MASK_ENTRYHI;
            CP0_ENTRYLO0: entrylo0_d      = mtc0_wdata & MASK_ENTRYLO;
            CP0_ENTRYLO1: entrylo1_d      = mtc0_wdata & MASK_ENTRYLO;
            CP0_WIRED:    wired_d         = mtc0_wdata[IW-1:0];
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               op_d = op_code;
               case (op_code)
                  TLBOP_P:  state_d = ST_PROBE;
                  TLBOP_R:  state_d = ST_READ;
                  TLBOP_WI: begin
                     state_d  = ST_WRITE;
                     wr_idx_d = index_q[IW-1:0];
                  end
                  TLBOP_WR: begin
                     state_d  = ST_WRITE;
                     wr_idx_d = random;
                  end
               endcase
            end
         end
         ST_PROBE: begin
            state_d = ST_IDLE;
            index_d = {~s_found, {(31-IW){1'b0}}, s_found ? s_index : index_q[IW-1:0]};
         end
         ST_READ: begin
            state_d    = ST_IDLE;
            entryhi_d  = {rd_e.vpn2, 5'b0, rd_e.asid};
            entrylo0_d = {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
            entrylo1_d = {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         op_q       <= TLBOP_P;
         wr_idx_q   <= '0;
         index_q    <= '0;
         entryhi_q  <= '0;
         entrylo0_q <= '0;
         entrylo1_q <= '0;
         wired_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         wr_idx_q   <= wr_idx_d;
         index_q    <= index_d;
         entryhi_q  <= entryhi_d;
         entrylo0_q <= entrylo0_d;
         entrylo1_q <= entrylo1_d;
         wired_q    <= wired_d;
      end
   end

   always_comb begin
      wr_e.vpn2 = entryhi_q[31:13];
      wr_e.asid = entryhi_q[7:0];
      wr_e.g    = entrylo0_q[0] & entrylo1_q[0];
      wr_e.pfn0 = entrylo0_q[25:6];
      wr_e.c0   = entrylo0_q[5:3];
      wr_e.d0   = entrylo0_q[2];
      wr_e.v0   = entrylo0_q[1];
      wr_e.pfn1 = entrylo1_q[25:6];
      wr_e.c1   = entrylo1_q[5:3];
      wr_e.d1   = entrylo1_q[2];
      wr_e.v1   = entrylo1_q[1];
   end

   assign op_ready     = (state_q == ST_IDLE);
   assign op_done      = !op_ready;
   assign flush_req    = op_done && (op_q != TLBOP_P);
   assign tlb_we       = (state_q == ST_WRITE);
   assign w_index      = wr_idx_q;
   assign w_entry      = tlb_pack(wr_e);
   assign r_index      = index_q[IW-1:0];
   assign s_vpn2       = entryhi_q[31:13];
   assign s_asid       = entryhi_q[7:0];
   assign cp0_index    = index_q;
   assign cp0_entryhi  = entryhi_q;
   assign cp0_entrylo0 = entrylo0_q;
   assign cp0_entrylo1 = entrylo1_q;
   assign cp0_wired    = {{(32-IW){1'b0}}, wired_q};
   assign cp0_random   = {{(32-IW){1'b0}}, random};

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: a 16-entry TLB model answers the search/read ports, and a
// cycle-level model of the CP0 registers and op sequencing predicts every output.
`timescale 1ns/1ps
module tb_tlb_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic [1:0]  op_code;
   logic        op_ready, op_done, flush_req;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [31:0] cp0_index, cp0_entrylo0, cp0_entrylo1, cp0_entryhi, cp0_random, cp0_wired;
   logic [18:0] s_vpn2;
   logic [7:0]  s_asid;
   logic        s_found;
   logic [3:0]  s_index;
   logic [3:0]  r_index;
   logic [77:0] r_entry;
   logic        tlb_we;
   logic [3:0]  w_index;
   logic [77:0] w_entry;

   always #5 clk = ~clk;

   tlb_ctrl dut (
      .clk(clk), .resetn(resetn),
      .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
      .flush_req(flush_req),
      .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
      .cp0_index(cp0_index), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
      .cp0_entryhi(cp0_entryhi), .cp0_random(cp0_random), .cp0_wired(cp0_wired),
      .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
      .r_index(r_index), .r_entry(r_entry),
      .tlb_we(tlb_we), .w_index(w_index), .w_entry(w_entry)
   );

   // ---------------- TLB environment ----------------
   logic [77:0] tlb_mem [16];

   function automatic logic hit(input logic [77:0] e, input logic [18:0] vpn2, input logic [7:0] asid);
      return (e[77:59] == vpn2) && (e[50] || (e[58:51] == asid));
   endfunction

   always_comb begin
      s_found = 1'b0;
      s_index = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (hit(tlb_mem[i], s_vpn2, s_asid)) begin
            s_found = 1'b1;
            s_index = 4'(i);
         end
      end
   end

   assign r_entry = tlb_mem[r_index];

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_busy;
   logic [1:0]  m_op;
   logic [3:0]  m_wr_idx;
   logic [31:0] m_index, m_ehi, m_elo0, m_elo1;
   logic [3:0]  m_wired, m_random;
   logic        accepted;

   function automatic logic [77:0] exp_wentry();
      return {m_ehi[31:13], m_ehi[7:0], m_elo0[0] & m_elo1[0],
              m_elo0[25:6], m_elo0[5:3], m_elo0[2], m_elo0[1],
              m_elo1[25:6], m_elo1[5:3], m_elo1[2], m_elo1[1]};
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_op = 2'b00; m_wr_idx = 4'd0;
      m_index = '0; m_ehi = '0; m_elo0 = '0; m_elo1 = '0;
      m_wired = 4'd0; m_random = 4'd15;
   endtask

   task automatic check_all();
      logic is_wr;
      is_wr = m_busy && m_op[1];
      chk("op_ready", 78'(op_ready), 78'(!m_busy));
      chk("op_done", 78'(op_done), 78'(m_busy));
      chk("flush_req", 78'(flush_req), 78'(m_busy && (m_op != 2'b00)));
      chk("tlb_we", 78'(tlb_we), 78'(is_wr));
      if (is_wr) begin
         chk("w_index", 78'(w_index), 78'(m_wr_idx));
         chk("w_entry", w_entry, exp_wentry());
      end
      chk("index", 78'(cp0_index), 78'(m_index));
      chk("entryhi", 78'(cp0_entryhi), 78'(m_ehi));
      chk("entrylo0", 78'(cp0_entrylo0), 78'(m_elo0));
      chk("entrylo1", 78'(cp0_entrylo1), 78'(m_elo1));
      chk("random", 78'(cp0_random), 78'(m_random));
      chk("wired", 78'(cp0_wired), 78'(m_wired));
      chk("s_vpn2", 78'(s_vpn2), 78'(m_ehi[31:13]));
      chk("s_asid", 78'(s_asid), 78'(m_ehi[7:0]));
      chk("r_index", 78'(r_index), 78'(m_index[3:0]));
   endtask

   // Advance one clock: predict from pre-edge state, commit at the edge, check at negedge.
   task automatic tick();
      logic        n_busy;
      logic [1:0]  n_op;
      logic [3:0]  n_wr, n_wired, n_random;
      logic [31:0] n_index, n_ehi, n_elo0, n_elo1;
      logic        do_wr;
      logic [3:0]  wr_at;
      logic [77:0] wr_e, e;
      int          hit_i;
      #1;
      n_busy = m_busy; n_op = m_op; n_wr = m_wr_idx;
      n_index = m_index; n_ehi = m_ehi; n_elo0 = m_elo0; n_elo1 = m_elo1;
      n_wired = m_wired;
      do_wr = 1'b0; wr_at = 4'd0; wr_e = '0;
      accepted = 1'b0;
      if (mtc0_we) begin
         case (mtc0_addr)
            5'd0:  n_index = {m_index[31:4], mtc0_wdata[3:0]};
            5'd2:  n_elo0 = mtc0_wdata & 32'h03FF_FFFF;
            5'd3:  n_elo1 = mtc0_wdata & 32'h03FF_FFFF;
            5'd6:  n_wired = mtc0_wdata[3:0];
            5'd10: n_ehi = mtc0_wdata & 32'hFFFF_E0FF;
            default: ;
         endcase
      end
      if (mtc0_we && mtc0_addr == 5'd6) n_random = 4'd15;
      else if (m_random == m_wired)     n_random = 4'd15;
      else                              n_random = m_random - 4'd1;
      if (m_busy) begin
         n_busy = 1'b0;
         case (m_op)
            2'b00: begin
               hit_i = -1;
               for (int i = 15; i >= 0; i--)
                  if (hit(tlb_mem[i], m_ehi[31:13], m_ehi[7:0])) hit_i = i;
               if (hit_i < 0) n_index = {1'b1, 27'd0, m_index[3:0]};
               else           n_index = {1'b0, 27'd0, 4'(hit_i)};
            end
            2'b01: begin
               e = tlb_mem[m_index[3:0]];
               n_ehi  = {e[77:59], 5'b0, e[58:51]};
               n_elo0 = {6'b0, e[49:30], e[29:27], e[26], e[25], e[50]};
               n_elo1 = {6'b0, e[24:5], e[4:2], e[1], e[0], e[50]};
            end
            default: begin
               do_wr = 1'b1; wr_at = m_wr_idx; wr_e = exp_wentry();
            end
         endcase
      end else if (op_valid) begin
         n_busy = 1'b1; n_op = op_code; accepted = 1'b1;
         n_wr = (op_code == 2'b10) ? m_index[3:0] : m_random;
      end
      @(posedge clk);
      m_busy = n_busy; m_op = n_op; m_wr_idx = n_wr;
      m_index = n_index; m_ehi = n_ehi; m_elo0 = n_elo0; m_elo1 = n_elo1;
      m_wired = n_wired; m_random = n_random;
      if (do_wr) tlb_mem[wr_at] = wr_e;
      @(negedge clk);
      check_all();
   endtask

   task automatic wr_cp0(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
      tick();
      mtc0_we = 1'b0;
   endtask

   task automatic issue(input logic [1:0] code);
      op_valid = 1'b1; op_code = code;
      tick();
      op_valid = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [8];
   logic [4:0] addr_pool [7] = '{5'd0, 5'd2, 5'd3, 5'd6, 5'd10, 5'd1, 5'd5};

   function automatic logic [31:0] cp0_rd(input logic [4:0] a);
      case (a)
         5'd0:    return cp0_index;
         5'd2:    return cp0_entrylo0;
         5'd3:    return cp0_entrylo1;
         5'd6:    return cp0_wired;
         default: return cp0_entryhi;
      endcase
   endfunction

   logic [3:0] exp_r;

   initial begin
      for (int i = 0; i < 16; i++)
         tlb_mem[i] = {19'h7FF00 + 19'(i), 8'hFF, 1'b0, 20'(i), 3'd0, 1'b0, 1'b0,
                       20'(i), 3'd0, 1'b0, 1'b0};
      tbl[0] = '{5'd10, 32'hFFFF_FFFF, 32'hFFFF_E0FF};
      tbl[1] = '{5'd2,  32'hFFFF_FFFF, 32'h03FF_FFFF};
      tbl[2] = '{5'd3,  32'hFFFF_FFFF, 32'h03FF_FFFF};
      tbl[3] = '{5'd0,  32'hFFFF_FFFF, 32'h0000_000F};
      tbl[4] = '{5'd6,  32'h0000_001F, 32'h0000_000F};
      tbl[5] = '{5'd6,  32'h0000_0000, 32'h0000_0000};
      tbl[6] = '{5'd10, 32'h1234_5678, 32'h1234_4078};
      tbl[7] = '{5'd0,  32'h0000_0005, 32'h0000_0005};

      resetn = 1'b0; op_valid = 1'b0; op_code = 2'b00;
      mtc0_we = 1'b0; mtc0_addr = 5'd0; mtc0_wdata = 32'd0; accepted = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_random", 78'(cp0_random), 78'(32'd15));
      chk("reset_ready", 78'(op_ready), 78'(1'b1));
      check_all();
      resetn = 1'b1;

      // Random counts 15 down to 0, then wraps.
      repeat (15) tick();
      chk("random_at_0", 78'(cp0_random), 78'(32'd0));
      tick();
      chk("random_wrap", 78'(cp0_random), 78'(32'd15));

      // Wired = 4: reload, count 15..4, wrap.
      repeat (3) tick();
      wr_cp0(5'd6, 32'd4);
      chk("wired_reload", 78'(cp0_random), 78'(32'd15));
      repeat (11) tick();
      chk("random_at_wired", 78'(cp0_random), 78'(32'd4));
      tick();
      chk("random_wired_wrap", 78'(cp0_random), 78'(32'd15));
      wr_cp0(5'd6, 32'd0);

      for (int i = 0; i < 8; i++) begin
         wr_cp0(tbl[i].addr, tbl[i].wdata);
         chk($sformatf("mask_vec%0d", i), 78'(cp0_rd(tbl[i].addr)), 78'(tbl[i].exp));
      end

      // TLBWI with known entry.
      wr_cp0(5'd10, 32'h0040_2005);
      wr_cp0(5'd2, 32'h0000_1047);
      wr_cp0(5'd3, 32'h0000_1087);
      wr_cp0(5'd0, 32'd3);
      issue(2'b10);
      chk("wi_we", 78'(tlb_we), 78'(1'b1));
      chk("wi_index", 78'(w_index), 78'(4'd3));
      chk("wi_entry", w_entry, {19'h00201, 8'h05, 1'b1, 20'h00041, 3'd0, 1'b1, 1'b1,
                                20'h00042, 3'd0, 1'b1, 1'b1});
      chk("wi_done_flush", 78'({op_done, flush_req}), 78'(2'b11));
      tick();
      chk("wi_we_single", 78'(tlb_we), 78'(1'b0));

      // TLBP hit.
      wr_cp0(5'd0, 32'd9);
      issue(2'b00);
      chk("p_no_flush", 78'({op_done, flush_req}), 78'(2'b10));
      tick();
      chk("probe_hit", 78'(cp0_index), 78'(32'h0000_0003));

      // Rewrite entry 3 non-global, then probe with another ASID.
      wr_cp0(5'd2, 32'h0000_1046);
      issue(2'b10);
      tick();
      wr_cp0(5'd10, 32'h0040_2006);
      issue(2'b00);
      tick();
      chk("probe_miss", 78'(cp0_index), 78'(32'h8000_0003));

      // TLBR from Index 3.
      issue(2'b01);
      tick();
      chk("tlbr_ehi", 78'(cp0_entryhi), 78'(32'h0040_2005));
      chk("tlbr_elo0", 78'(cp0_entrylo0), 78'(32'h0000_1046));
      chk("tlbr_elo1", 78'(cp0_entrylo1), 78'(32'h0000_1086));

      // mtc0 Index on the probe-end edge loses to the probe.
      wr_cp0(5'd0, 32'd9);
      issue(2'b00);
      mtc0_we = 1'b1; mtc0_addr = 5'd0; mtc0_wdata = 32'd7;
      tick();
      mtc0_we = 1'b0;
      chk("probe_wins", 78'(cp0_index), 78'(32'h0000_0003));

      // TLBWR uses Random at acceptance.
      exp_r = m_random;
      issue(2'b11);
      chk("wr_index", 78'(w_index), 78'(exp_r));
      tick();

      // Reset in the middle of WRITE.
      issue(2'b10);
      resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_we", 78'(tlb_we), 78'(1'b0));
      chk("rst_idle", 78'({op_ready, op_done}), 78'(2'b10));
      check_all();
      @(negedge clk);
      resetn = 1'b1;
      check_all();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         if (!op_valid && $urandom_range(0, 2) == 0) begin
            op_valid = 1'b1;
            op_code  = 2'($urandom_range(0, 3));
         end
         mtc0_we   = ($urandom_range(0, 3) == 0);
         mtc0_addr = addr_pool[$urandom_range(0, 6)];
         if (mtc0_addr == 5'd10)
            mtc0_wdata = {17'd0, 2'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))};
         else
            mtc0_wdata = $urandom();
         tick();
         if (accepted) op_valid = 1'b0;
      end
      mtc0_we = 1'b0;
      op_valid = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
